alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end for the combinational alu block (WIDTH-bit A/B, 4-bit ALU_OP, RESULT/ZERO/CARRY/OVERFLOW).
- Upstream: accepts operation commands on a valid/ready interface and buffers them in a small FIFO.
- Toward the alu: drives registered operands and opcode into it.
- Downstream: captures RESULT and the flags into a response register with valid/ready.
- Keeps an accumulator, so a command can chain on the previous result, plus a count of completed operations.

Parameters:
WIDTH, 8, operand/result width; must match the attached alu.
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals !fifo_full.
cmd_op  input  4  ALU opcode, passed to alu unchanged.
cmd_a  input  WIDTH  operand A; ignored when cmd_use_acc=1.
cmd_b  input  WIDTH  operand B.
cmd_use_acc  input  1  1 = use the accumulator as operand A.
alu_a  output  WIDTH  registered operand A to the alu.
alu_b  output  WIDTH  registered operand B to the alu.
alu_op  output  4  registered opcode to the alu.
alu_result  input  WIDTH  alu RESULT.
alu_zero  input  1  alu ZERO.
alu_carry  input  1  alu CARRY.
alu_overflow  input  1  alu OVERFLOW.
rsp_valid  output  1  response register holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  WIDTH  captured result.
rsp_flags  output  3  captured flags, ordered {overflow, carry, zero}.
acc  output  WIDTH  accumulator (last captured result).
op_count  output  16  completed responses; wraps at 16'hFFFF.
busy  output  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM to IDLE and FIFO empty.
  - All outputs are 0 during reset, except cmd_ready=1 (FIFO empty).
  - Any in-flight command or pending response is discarded.
  - Deasserting rst_n mid-operation restarts cleanly from IDLE.
- Push: on a cycle with cmd_valid && cmd_ready, {op, a, b, use_acc} is written to the FIFO tail.
  - Pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished.
  - No bypass: a command pushed into an empty FIFO pops at the earliest on the next edge.
- FSM states: IDLE, EXEC, WB.
- IDLE: if the FIFO is non-empty, pop the head and register it:
  - alu_op <= op; alu_b <= b;
  - alu_a <= use_acc ? acc : a;
  - go to EXEC. Otherwise stay in IDLE.
- EXEC (one cycle): the alu settles combinationally. At the edge:
  - rsp_result <= alu_result; rsp_flags <= {alu_overflow, alu_carry, alu_zero};
  - acc <= alu_result; rsp_valid <= 1;
  - go to WB.
- WB: hold the rsp_* outputs stable while rsp_valid && !rsp_ready. When rsp_ready=1:
  - rsp_valid <= 0 and op_count <= op_count + 1 (modulo 2^16).
  - If the FIFO is non-empty, pop the next command exactly as in IDLE and go directly to EXEC; otherwise go to IDLE.
- Operand registers hold their values outside the issue edge.
- Latency: command pushed at edge T0 → popped at T1 → rsp_valid=1 after T2. The push-to-response minimum is 2 edges after the push edge.
- Throughput: 1 response per 2 cycles with rsp_ready held at 1.
- Accumulator dependency: only one command is in flight, so use_acc always sees the result of the immediately preceding command. No forwarding is needed.
- Simultaneous push and pop: allowed whenever the FIFO is not full. Occupancy is unchanged.
- Full FIFO: cmd_ready=0; a push attempt is ignored. A pop in the same cycle raises cmd_ready on the following cycle only (no same-cycle full bypass).
- Opcodes 4'b1010–4'b1111 are not checked here. They are forwarded to the alu and the alu output is captured as-is (result 0, zero flag 1).
- Arithmetic: none is performed here besides pointer and op_count increments. rsp_result is exactly WIDTH bits, with no extension.

Test Plan:
- Reset, then push {ADD, A=8'h14, B=8'h22} → rsp_valid rises 2 edges after the push; rsp_result=8'h36, rsp_flags=3'b000, acc=8'h36, op_count=1.
- Push {ADD, 8'h80, 8'h80}, then {ADD, use_acc=1, B=8'h05} → first response 8'h00 with flags 3'b111; second response 8'h05 with flags 3'b000 (acc chained).
- rsp_ready=0; push 5 commands (DEPTH=4) → 1 issues and waits in WB; 4 fill the FIFO; cmd_ready=0 and the 6th push is ignored. Raise rsp_ready → exactly 5 responses in push order; op_count=5.
- rsp_ready held at 1; stream {SUB 8'h50, 8'h10} repeatedly → each response is 8'h40, flags 3'b000; rsp_valid pulses every 2nd cycle; no response is lost or duplicated.
- Assert rst_n=0 while in EXEC with 2 entries queued → immediately rsp_valid=0, acc=0, op_count=0, cmd_ready=1; after release, nothing issues until a new push.
- Push opcode 4'b1111 → rsp_result=0, rsp_flags=3'b001, op_count increments.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for a combinational alu.
// Commands are buffered in a small FIFO and issued to the alu one at a time.
// Each result is captured into a valid/ready response register and becomes
// the accumulator, so a command can use the previous result as operand A.
`timescale 1ns/1ps

module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      op_count,
  output logic             busy
);

  // One extra pointer bit separates the full and empty cases.
  localparam int PTR_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  state_t           r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [2:0]       r_rsp_flags;
  logic [WIDTH-1:0] r_acc;
  logic [15:0]      r_op_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  cmd_t w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
  assign w_push  = cmd_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[PTR_W-2:0]];
  // A command issues from IDLE, or straight out of WB as the response leaves.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) ||
                                ((r_state == S_WB) && rsp_ready));

  // FIFO storage: written at the tail on an accepted push.
  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and the pointers (which are reset) decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-2:0]] <= '{op: cmd_op, a: cmd_a, b: cmd_b,
                                      use_acc: cmd_use_acc};
    end
  end

  // Tail pointer advances on every accepted push.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Issue/execute/write-back sequencer with registered alu and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rd_ptr     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_acc        <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_pop) begin
        r_alu_op <= w_head.op;
        r_alu_b  <= w_head.b;
        r_alu_a  <= w_head.use_acc ? r_acc : w_head.a;
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_flags  <= {alu_overflow, alu_carry, alu_zero};
          r_acc        <= alu_result;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_WB;
        end
        S_WB: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= w_pop ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign acc        = r_acc;
  assign op_count   = r_op_count;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural alu closes the loop, a
// stimulus process pushes expected responses into a queue, and a monitor
// pops and compares on every response handshake.
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        cmd_use_acc = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_carry, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_result;
  logic [2:0]  rsp_flags;
  logic [7:0]  acc;
  logic [15:0] op_count;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] exp_q[$];      // {overflow, carry, zero, result}
  logic [7:0]  model_acc = '0;
  int          model_count = 0;
  int          cyc = 0;
  int          prev_hs = 0;
  bit          have_prev = 0;
  bit          gap_en = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .acc(acc), .op_count(op_count), .busy(busy)
  );

  // Behavioural alu: returns {overflow, carry, zero, result}.
  // SUB reports borrow in carry; opcodes 10..15 give result 0.
  function automatic logic [10:0] alu_model(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd7: r = a;
      4'd8: r = b;
      4'd9: r = ~a;
      default: r = '0;
    endcase
    return {v, c, (r == 8'd0), r};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_result} =
         alu_model(alu_op, alu_a, alu_b);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison set per response handshake.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      model_count = 0;
      have_prev   = 0;
    end else if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_result", 32'(rsp_result), 32'(e[7:0]));
        check("rsp_flags", 32'(rsp_flags), 32'(e[10:8]));
        check("acc_eq_result", 32'(acc), 32'(e[7:0]));
        check("op_count_before", 32'(op_count), 32'(model_count[15:0]));
      end
      if (gap_en && have_prev) check("rsp_gap", 32'(cyc - prev_hs), 32'd2);
      prev_hs     = cyc;
      have_prev   = 1;
      model_count = model_count + 1;
    end
  end

  // Drive one command cycle (called just after a rising edge); reports
  // whether the DUT accepted it and records the expected response if so.
  task automatic drive_cycle(input bit v, input logic [3:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input bit ua, output bit ok);
    logic [10:0] r;
    cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(negedge clk);
    ok = v && cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      r = alu_model(op, ua ? model_acc : a, b);
      exp_q.push_back(r);
      model_acc = r[7:0];
    end
  endtask

  task automatic push_wait(input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input bit ua);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) drive_cycle(1, op, a, b, ua, ok);
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    gap_en    = 0;
    rst_n     = 1'b0;
    exp_q.delete();
    model_acc = '0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_regs", {12'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_rsp_regs", {21'd0, rsp_flags, rsp_result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy && !rsp_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_done", {31'd0, busy || rsp_valid}, 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int sent;

    // Reset, then a single ADD with latency check.
    do_reset();
    rsp_ready = 1'b1;
    drive_cycle(1, OP_ADD, 8'h14, 8'h22, 0, ok);
    check("t1_accept", 32'(ok), 32'd1);
    check("t1_valid_t0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_t1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_t2", 32'(rsp_valid), 32'd1);
    check("t1_result", 32'(rsp_result), 32'h36);
    wait_drain();
    check("t1_acc", 32'(acc), 32'h36);
    check("t1_op_count", 32'(op_count), 32'd1);

    // Overflowing ADD, then an accumulator-chained ADD.
    do_reset();
    rsp_ready = 1'b1;
    push_wait(OP_ADD, 8'h80, 8'h80, 0);
    push_wait(OP_ADD, 8'hFF, 8'h05, 1);
    wait_drain();
    check("t2_acc", 32'(acc), 32'h05);
    check("t2_op_count", 32'(op_count), 32'd2);

    // Back-pressure: fill the FIFO behind a stalled response.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 4'(i + 2), 8'(8'h31 * (i + 1)), 8'(8'h1D + i), 0, ok);
      check("t3_push_ok", 32'(ok), 32'd1);
    end
    drive_cycle(1, OP_ADD, 8'h01, 8'h01, 0, ok);
    check("t3_push6_ignored", 32'(ok), 32'd0);
    check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t3_rsp_waiting", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    wait_drain();
    check("t3_op_count", 32'(op_count), 32'd5);

    // Streaming SUBs with rsp_ready held high: one response per 2 cycles.
    do_reset();
    rsp_ready = 1'b1;
    gap_en    = 1;
    sent      = 0;
    for (int i = 0; i < 100 && sent < 8; i++) begin
      drive_cycle(1, OP_SUB, 8'h50, 8'h10, 0, ok);
      if (ok) sent++;
    end
    check("t4_sent", 32'(sent), 32'd8);
    wait_drain();
    gap_en = 0;
    check("t4_op_count", 32'(op_count), 32'd8);
    check("t4_acc", 32'(acc), 32'h40);

    // Reset while executing with two commands queued.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, OP_ADD, 8'(i + 1), 8'h10, 0, ok);
      check("t5_push_ok", 32'(ok), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("t5_in_exec_busy", 32'(busy), 32'd1);
    check("t5_in_exec_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    model_acc = '0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_acc", 32'(acc), 32'd0);
    check("t5_rst_op_count", 32'(op_count), 32'd0);
    check("t5_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_issue_busy", 32'(busy), 32'd0);
    check("t5_no_issue_count", 32'(op_count), 32'd0);

    // Unchecked opcode is forwarded and its alu output captured as-is.
    rsp_ready = 1'b1;
    push_wait(4'b1111, 8'hA5, 8'h5A, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_result", 32'(rsp_result), 32'h00);
    check("t6_flags", 32'(rsp_flags), 32'b001);
    wait_drain();
    check("t6_op_count", 32'(op_count), 32'd1);

    // Randomized traffic with random back-pressure.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive_cycle(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), ok);
    end
    rsp_ready = 1'b1;
    wait_drain();
    check("rand_op_count", 32'(op_count), 32'(model_count[15:0]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
